demux4_router: RTL
==================

# demux4_router

Registered 1-to-4 demultiplexer with valid/ready handshaking on every port. It is the distribution-side counterpart of the datapath 4:1 `mux`. A single WIDTH-bit stream enters with a 2-bit select (`s1`,`s0`), and each word is steered into one of four single-entry output buffers (`out_data0`..`out_data3`). It sits between the ALU/writeback result source and four independent consumers. Because each channel has its own buffer, a stalled consumer blocks only its own channel.

## Interface
- `WIDTH`, default 32: data width of input and all four outputs.
- `clk`  input  1  rising-edge clock; all state updates on posedge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  producer presents a word.
- `in_ready`  output  1  block accepts the word this cycle (combinational).
- `in_data`  input  WIDTH  word to route.
- `s0`, `s1`  input  1 each  channel select, `sel = {s1,s0}`. Must be stable with `in_valid`.
- `out_valid`  output  4  bit k = channel k buffer holds a word.
- `out_ready`  input  4  bit k = consumer k takes the word this cycle.
- `out_data0`..`out_data3`  output  WIDTH each  buffer contents of channels 0..3.
- `acc_count`  output  8  number of accepted input words, wrapping.

## Operation
- State per channel k: `full[k]` and `buf[k]` (WIDTH bits). `out_valid[k] = full[k]` and `out_dataK = buf[k]`, both straight from registers.
- Input ready: `in_ready = !full[sel] || out_ready[sel]`.
  - This depends only on the selected channel; other channels' fullness is ignored.
  - `in_ready` never depends on `in_valid`.
- Accept: `acc = in_valid && in_ready`.
- Channel k update, priority order:
  - `acc && sel==k`: `buf[k] <= in_data`, `full[k] <= 1`. This covers the simultaneous drain+refill case, with no bubble.
  - Else `full[k] && out_ready[k]`: `full[k] <= 0`. `buf[k]` keeps its old value; don't-care when not valid.
  - Else: hold.
- Unselected channels drain independently in the same cycle as an accept on another channel.
- Stability: while `full[k] && !out_ready[k]`, `buf[k]` and `out_valid[k]` hold unchanged.
- `acc_count` increments by 1 on every `acc`. It wraps from 255 to 0.
- Routing uses only `sel`. `in_data` and `sel` are ignored when `in_valid = 0`.

## Timing
- Reset (synchronous, takes effect at the posedge where `reset = 1`):
  - `full = 4'b0000`, `out_valid = 4'b0000`.
  - all `buf` = 0, so `out_data0..3 = 0`.
  - `acc_count = 0`.
- Reset overrides any simultaneous accept or drain. A word accepted or buffered in the reset cycle is discarded and not counted.
- `in_ready` is 1 in the cycle reset is deasserted, since all buffers are empty.
- Latency: a word accepted at edge N appears with `out_valid[sel] = 1` after edge N, i.e. in cycle N+1.
- Throughput: 1 word/clock to one channel, provided its consumer holds `out_ready = 1`.
  - Back-to-back words to alternating channels with idle consumers: the first two fill; the third to an already-full channel stalls.
- Full channel with `out_ready[sel] = 0`: `in_ready = 0`, the producer holds its word, and no state changes for that channel.
- Combinational path `out_ready[sel]` -> `in_ready` is allowed. It must not form a loop with the producer.
- A select change while `in_valid = 0` has no effect. A select change with `in_valid = 1` is a producer protocol violation; the behaviour is whatever the current-cycle `sel` dictates.

## Test plan
- Reset/idle: assert `reset` for 2 cycles. Expect `out_valid = 0000`, all `out_data = 0`, `acc_count = 0`, `in_ready = 1`.
- Routing sweep: send 0xA0000000, 0xA1111111, 0xA2222222, 0xA3333333 with `sel` = 0,1,2,3 on consecutive cycles, all `out_ready = 0`.
  - Expect `out_valid` to go 0001, 0011, 0111, 1111 one cycle after each accept.
  - Expect each `out_dataK` to carry its own word.
  - Expect `acc_count = 4`.
- Backpressure: with channel 2 full and `out_ready[2] = 0`, present 0xDEADBEEF with `sel = 2`.
  - Expect `in_ready = 0` and `out_data2` unchanged.
  - Raise `out_ready[2]`: expect `in_ready = 1` the same cycle, `out_data2 = 0xDEADBEEF` next cycle, `out_valid[2]` still 1.
- Independent drain: channel 1 full, `out_ready = 0010`, accept to channel 3 in the same cycle.
  - Expect next cycle `out_valid[1] = 0`, `out_valid[3] = 1`, `acc_count` +1.
- Streaming and wrap: `sel = 0`, `out_ready[0] = 1`, `in_valid` held for 256 cycles with incrementing data.
  - Expect `in_ready = 1` every cycle.
  - Expect `out_data0` to trail `in_data` by one cycle.
  - Expect `acc_count` to return to 0 after the 256th accept.
- Reset mid-operation: assert `reset` in the cycle of an accept to channel 0 while channels 1–3 are full.
  - Expect next cycle `out_valid = 0000`, all data 0, `acc_count = 0`.

Source files
------------

// File: rtl/demux4_router.sv
// Registered 1-to-4 demultiplexer. Each channel has a single-entry buffer with a valid/ready
// handshake, so a stalled consumer only blocks words routed to its own channel.
module demux4_router #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s0,
  input  logic             s1,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       acc_count
);

  logic [1:0]       sel;
  logic             acc;
  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
  logic [7:0]       count_q, count_d;

  assign sel = {s1, s0};

  // A full channel can still accept when its consumer drains in the same cycle.
  assign in_ready = !full_q[sel] || out_ready[sel];
  assign acc      = in_valid && in_ready;

  always_comb begin
    full_d  = full_q;
    count_d = count_q;
    for (int k = 0; k < 4; k++) begin
      buf_d[k] = buf_q[k];
      if (acc && (sel == 2'(k))) begin
        buf_d[k]  = in_data;
        full_d[k] = 1'b1;
      end else if (full_q[k] && out_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end
    if (acc) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 4'b0000;
      count_q <= 8'd0;
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      full_q  <= full_d;
      count_q <= count_d;
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign out_valid = full_q;
  assign out_data0 = buf_q[0];
  assign out_data1 = buf_q[1];
  assign out_data2 = buf_q[2];
  assign out_data3 = buf_q[3];
  assign acc_count = count_q;

endmodule
